// File: rtl/pit_pkg.sv
// rtl/pit_pkg.sv - shared types, constants and helpers for the 8254 bus-side control logic
package pit_pkg;

   typedef enum logic [1:0] {
      LATCH   = 2'b00,
      LSB     = 2'b01,
      MSB     = 2'b10,
      LSB_MSB = 2'b11
   } rw_e;

   typedef logic [2:0] mode_t;

   localparam logic [1:0] CTRL_ADDR = 2'd3;

   // Read-back status byte layout: {OUT, NULL, RW[1:0], M[2:0], BCD}
   localparam int ST_OUT_BIT  = 7;
   localparam int ST_NULL_BIT = 6;
   localparam int ST_RW_LSB   = 4;
   localparam int ST_MODE_LSB = 1;
   localparam int ST_BCD_BIT  = 0;

   // Modes 6 and 7 are aliases of modes 2 and 3
   function automatic mode_t map_mode(input logic [2:0] m);
      return (m[2:1] == 2'b11) ? {1'b0, m[1:0]} : m;
   endfunction

endpackage

// File: rtl/pit_counter_port.sv
// rtl/pit_counter_port.sv - per-counter format, pointers, LSB staging, count latch and status latch
module pit_counter_port
   import pit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl_we,
   input  logic        latch_cmd,
   input  logic        status_cmd,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [7:0]  din,
   input  logic [15:0] cur_count,
   input  logic        cnt_out,
   output logic [15:0] count,
   output logic        new_count,
   output mode_t       mode,
   output logic        bcd,
   output logic [7:0]  rd_byte
);

   rw_e         rw_d, rw_q;
   mode_t       mode_d, mode_q;
   logic        bcd_d, bcd_q;
   logic        wr_ptr_d, wr_ptr_q;
   logic        rd_ptr_d, rd_ptr_q;
   logic [7:0]  lsb_d, lsb_q;
   logic [15:0] latch_d, latch_q;
   logic        latch_vld_d, latch_vld_q;
   logic [7:0]  status_d, status_q;
   logic        status_vld_d, status_vld_q;
   logic        null_d, null_q;
   logic [15:0] count_d, count_q;
   logic        new_count_d, new_count_q;
   logic [15:0] src;
   logic        sel_msb;

   // Next-state for programming, byte sequencing and latches; read byte selection
   always_comb begin
      rw_d         = rw_q;
      mode_d       = mode_q;
      bcd_d        = bcd_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      lsb_d        = lsb_q;
      latch_d      = latch_q;
      latch_vld_d  = latch_vld_q;
      status_d     = status_q;
      status_vld_d = status_vld_q;
      null_d       = null_q;
      count_d      = count_q;
      new_count_d  = 1'b0;

      src     = latch_vld_q ? latch_q : cur_count;
      sel_msb = (rw_q == MSB) || ((rw_q == LSB_MSB) && rd_ptr_q);
      rd_byte = status_vld_q ? status_q : (sel_msb ? src[15:8] : src[7:0]);

      if (ctrl_we) begin
         rw_d         = rw_e'(din[5:4]);
         mode_d       = map_mode(din[3:1]);
         bcd_d        = din[0];
         wr_ptr_d     = 1'b0;
         rd_ptr_d     = 1'b0;
         latch_vld_d  = 1'b0;
         status_vld_d = 1'b0;
         null_d       = 1'b1;
      end else begin
         // cur_count is sampled directly, so a same-cycle load still latches the pre-load value
         if (latch_cmd && !latch_vld_q) begin
            latch_d     = cur_count;
            latch_vld_d = 1'b1;
         end
         if (status_cmd && !status_vld_q) begin
            status_d[ST_OUT_BIT]           = cnt_out;
            status_d[ST_NULL_BIT]          = null_q;
            status_d[ST_RW_LSB +: 2]       = rw_q;
            status_d[ST_MODE_LSB +: 3]     = mode_q;
            status_d[ST_BCD_BIT]           = bcd_q;
            status_vld_d                   = 1'b1;
         end
         if (wr_en) begin
            case (rw_q)
               LSB: begin
                  count_d     = {8'h00, din};
                  new_count_d = 1'b1;
                  null_d      = 1'b0;
               end
               MSB: begin
                  count_d     = {din, 8'h00};
                  new_count_d = 1'b1;
                  null_d      = 1'b0;
               end
               LSB_MSB: begin
                  if (!wr_ptr_q) begin
                     lsb_d    = din;
                     wr_ptr_d = 1'b1;
                  end else begin
                     count_d     = {din, lsb_q};
                     new_count_d = 1'b1;
                     null_d      = 1'b0;
                     wr_ptr_d    = 1'b0;
                  end
               end
               default: ;
            endcase
         end
         if (rd_en) begin
            if (status_vld_q) begin
               status_vld_d = 1'b0;
            end else begin
               if (rw_q == LSB_MSB) rd_ptr_d = ~rd_ptr_q;
               if (latch_vld_q && ((rw_q != LSB_MSB) || rd_ptr_q)) latch_vld_d = 1'b0;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rw_q         <= LATCH;
         mode_q       <= '0;
         bcd_q        <= 1'b0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         lsb_q        <= '0;
         latch_q      <= '0;
         latch_vld_q  <= 1'b0;
         status_q     <= '0;
         status_vld_q <= 1'b0;
         null_q       <= 1'b0;
         count_q      <= '0;
         new_count_q  <= 1'b0;
      end else begin
         rw_q         <= rw_d;
         mode_q       <= mode_d;
         bcd_q        <= bcd_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         lsb_q        <= lsb_d;
         latch_q      <= latch_d;
         latch_vld_q  <= latch_vld_d;
         status_q     <= status_d;
         status_vld_q <= status_vld_d;
         null_q       <= null_d;
         count_q      <= count_d;
         new_count_q  <= new_count_d;
      end
   end

   assign count     = count_q;
   assign new_count = new_count_q;
   assign mode      = mode_q;
   assign bcd       = bcd_q;

endmodule

// File: rtl/pit_control_logic.sv
// rtl/pit_control_logic.sv - 8254 bus decode and read mux; PIT_READBACK_EN enables the read-back command
module pit_control_logic
   import pit_pkg::*;
#(
   parameter int NUM_CNT = 3
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cs,
   input  logic                      wr,
   input  logic                      rd,
   input  logic [1:0]                a,
   input  logic [7:0]                din,
   output logic [7:0]                dout,
   output logic                      dout_valid,
   input  logic [NUM_CNT-1:0][15:0]  cur_count,
   input  logic [NUM_CNT-1:0]        cnt_out,
   output logic [NUM_CNT-1:0][15:0]  count,
   output logic [NUM_CNT-1:0]        new_count,
   output logic [NUM_CNT-1:0][2:0]   mode,
   output logic [NUM_CNT-1:0]        bcd
);

   logic [NUM_CNT-1:0]       port_ctrl, port_latch, port_status, port_wr, port_rd;
   logic [NUM_CNT-1:0][7:0]  rd_byte;
   logic                     wr_act, rd_act, ctrl_wr;
   logic [7:0]               dout_d, dout_q;
   logic                     dout_valid_d, dout_valid_q;

   // Decode bus strobes into per-counter commands; a write wins over a same-cycle read
   always_comb begin
      wr_act  = cs & wr;
      rd_act  = cs & rd & ~wr;
      ctrl_wr = wr_act && (a == CTRL_ADDR);
      for (int i = 0; i < NUM_CNT; i++) begin
         port_ctrl[i]   = ctrl_wr && (din[7:6] == 2'(i)) && (din[5:4] != 2'b00);
         port_latch[i]  = ctrl_wr && (din[7:6] == 2'(i)) && (din[5:4] == 2'b00);
         port_status[i] = 1'b0;
`ifdef PIT_READBACK_EN
         if (ctrl_wr && (din[7:6] == CTRL_ADDR) && din[1+i]) begin
            port_latch[i]  = ~din[5];
            port_status[i] = ~din[4];
         end
`endif
         port_wr[i] = wr_act && (a == 2'(i));
         port_rd[i] = rd_act && (a == 2'(i));
      end
   end

   // Read data mux; the control address reads back as all ones
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      if (rd_act) begin
         dout_valid_d = 1'b1;
         dout_d       = 8'hFF;
         for (int i = 0; i < NUM_CNT; i++) begin
            if (a == 2'(i)) dout_d = rd_byte[i];
         end
      end
   end

   // Registered read port
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_port
      pit_counter_port u_port (
         .clk        (clk),
         .rst        (rst),
         .ctrl_we    (port_ctrl[g]),
         .latch_cmd  (port_latch[g]),
         .status_cmd (port_status[g]),
         .wr_en      (port_wr[g]),
         .rd_en      (port_rd[g]),
         .din        (din),
         .cur_count  (cur_count[g]),
         .cnt_out    (cnt_out[g]),
         .count      (count[g]),
         .new_count  (new_count[g]),
         .mode       (mode[g]),
         .bcd        (bcd[g]),
         .rd_byte    (rd_byte[g])
      );
   end

endmodule

// File: tb/tb_pit_control_logic.sv
// tb/tb_pit_control_logic.sv - scoreboard bench for pit_control_logic
module tb_pit_control_logic;

   logic             clk = 1'b0;
   logic             rst;
   logic             cs, wr, rd;
   logic [1:0]       a;
   logic [7:0]       din;
   logic [7:0]       dout;
   logic             dout_valid;
   logic [2:0][15:0] cur_count;
   logic [2:0]       cnt_out;
   logic [2:0][15:0] count;
   logic [2:0]       new_count;
   logic [2:0][2:0]  mode;
   logic [2:0]       bcd;

   typedef struct {
      int          idx;
      logic [15:0] cnt;
      logic [2:0]  md;
      logic        b;
   } ld_t;

   logic [7:0] exp_rd[$];
   ld_t        exp_ld[$];
   int         checks = 0;
   int         errors = 0;
   logic       chk_reset = 1'b0;
   logic       done = 1'b0;

   pit_control_logic #(.NUM_CNT(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .cs         (cs),
      .wr         (wr),
      .rd         (rd),
      .a          (a),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .cur_count  (cur_count),
      .cnt_out    (cnt_out),
      .count      (count),
      .new_count  (new_count),
      .mode       (mode),
      .bcd        (bcd)
   );

   always #5 clk = ~clk;

   task automatic bus(input logic w, input logic r, input logic [1:0] ad, input logic [7:0] d);
      cs = 1'b1; wr = w; rd = r; a = ad; din = d;
      @(posedge clk); #1;
      cs = 1'b0; wr = 1'b0; rd = 1'b0;
   endtask

   task automatic push_ld(input int idx, input logic [15:0] c, input logic [2:0] m, input logic b);
      ld_t e;
      e.idx = idx; e.cnt = c; e.md = m; e.b = b;
      exp_ld.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: all comparisons happen here, on the falling edge
   always @(negedge clk) begin
      ld_t        e;
      logic [7:0] eb;
      logic [2:0] onehot;
      if (chk_reset) begin
         chk("rst_dout", 32'(dout), 32'h0);
         chk("rst_dout_valid", 32'(dout_valid), 32'h0);
         chk("rst_new_count", 32'(new_count), 32'h0);
         chk("rst_mode", 32'(mode), 32'h0);
         chk("rst_bcd", 32'(bcd), 32'h0);
         for (int i = 0; i < 3; i++) chk("rst_count", 32'(count[i]), 32'h0);
      end else if (!rst) begin
         if (dout_valid) begin
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read: got dout %h expected no read", dout);
            end else begin
               eb = exp_rd.pop_front();
               chk("read_byte", 32'(dout), 32'(eb));
            end
         end
         if (new_count != 3'b000) begin
            if (exp_ld.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_load: got new_count %b expected none", new_count);
            end else begin
               e = exp_ld.pop_front();
               onehot = 3'b001 << e.idx;
               chk("load_strobe", 32'(new_count), 32'(onehot));
               chk("load_count", 32'(count[e.idx]), 32'(e.cnt));
               chk("load_mode", 32'(mode[e.idx]), 32'(e.md));
               chk("load_bcd", 32'(bcd[e.idx]), 32'(e.b));
            end
         end
      end
      if (done) begin
         chk("reads_pending", exp_rd.size(), 32'h0);
         chk("loads_pending", exp_ld.size(), 32'h0);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; a = 2'd0; din = 8'h00;
      cur_count = '0; cnt_out = 3'b000;
      repeat (3) @(posedge clk); #1;
      chk_reset = 1'b1;
      @(posedge clk); #1;
      chk_reset = 1'b0; rst = 1'b0;

      // Counter 0, LSB then MSB, mode 0
      bus(1, 0, 3, 8'h30);
      push_ld(0, 16'h1234, 3'd0, 1'b0);
      bus(1, 0, 0, 8'h34);
      bus(1, 0, 0, 8'h12);

      // Counter 1, LSB only, then MSB only in mode 1
      bus(1, 0, 3, 8'h50);
      push_ld(1, 16'h00AB, 3'd0, 1'b0);
      bus(1, 0, 1, 8'hAB);
      bus(1, 0, 3, 8'h62);
      push_ld(1, 16'hCD00, 3'd1, 1'b0);
      bus(1, 0, 1, 8'hCD);

      // Latch counter 0, then the live value moves on
      cur_count[0] = 16'h0F0E;
      bus(1, 0, 3, 8'h00);
      cur_count[0] = 16'h0001;
      exp_rd.push_back(8'h0E); exp_rd.push_back(8'h0F); exp_rd.push_back(8'h01);
      bus(0, 1, 0, 8'h00);
      bus(0, 1, 0, 8'h00);
      bus(0, 1, 0, 8'h00);

      // Control word after the LSB aborts the sequence
      bus(1, 0, 3, 8'hB0);
      bus(1, 0, 2, 8'h11);
      bus(1, 0, 3, 8'hB0);
      push_ld(2, 16'h3322, 3'd0, 1'b0);
      bus(1, 0, 2, 8'h22);
      bus(1, 0, 2, 8'h33);

      // Simultaneous write and read: write wins, read dropped
      push_ld(1, 16'h5A00, 3'd1, 1'b0);
      bus(1, 1, 1, 8'h5A);

      // Control address reads as FF
      exp_rd.push_back(8'hFF);
      bus(0, 1, 3, 8'h00);

      // Second latch while one is held is ignored
      cur_count[2] = 16'h1357;
      bus(1, 0, 3, 8'h80);
      cur_count[2] = 16'h2468;
      bus(1, 0, 3, 8'h80);
      exp_rd.push_back(8'h57); exp_rd.push_back(8'h13); exp_rd.push_back(8'h68);
      bus(0, 1, 2, 8'h00);
      bus(0, 1, 2, 8'h00);
      bus(0, 1, 2, 8'h00);

      // Mode 6 aliases to mode 2, BCD flag set
      bus(1, 0, 3, 8'h1D);
      push_ld(0, 16'h0042, 3'd2, 1'b1);
      bus(1, 0, 0, 8'h42);

      // SC=11: read-back when enabled, otherwise ignored
      bus(1, 0, 3, 8'h34);
      cur_count[0] = 16'hBEEF;
      cnt_out = 3'b001;
      bus(1, 0, 3, 8'hC2);
      cur_count[0] = 16'hC3A5;
`ifdef PIT_READBACK_EN
      exp_rd.push_back(8'hF4); exp_rd.push_back(8'hEF); exp_rd.push_back(8'hBE);
      bus(0, 1, 0, 8'h00);
      bus(0, 1, 0, 8'h00);
      bus(0, 1, 0, 8'h00);
`else
      exp_rd.push_back(8'hA5); exp_rd.push_back(8'hC3);
      bus(0, 1, 0, 8'h00);
      bus(0, 1, 0, 8'h00);
`endif

      // Reset mid-sequence, then a write to an unprogrammed counter
      bus(1, 0, 3, 8'h30);
      bus(1, 0, 0, 8'h77);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset = 1'b1;
      @(posedge clk); #1;
      chk_reset = 1'b0; rst = 1'b0;
      bus(1, 0, 0, 8'h99);
      bus(1, 0, 3, 8'h30);
      push_ld(0, 16'h0201, 3'd0, 1'b0);
      bus(1, 0, 0, 8'h01);
      bus(1, 0, 0, 8'h02);

      repeat (5) @(posedge clk); #1;
      done = 1'b1;
   end

endmodule
